// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction decode stage. Holds the IF/ID pipeline register,
//                a 32x32 register file with write-through bypass, load-use
//                hazard detection (stalls fetch, bubbles EX) and a halt latch.
//  Revision    : 1.0  initial release
// ============================================================================
module id_stage #(
    parameter int                 NUM_REGS  = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [5:0]         HALT_OP   = 6'b110001,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc_1,
    input  logic              if_pred_taken,
    input  logic              changeFlow,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_PC,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc_1,
    output logic              id_pred_taken,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_sext,
    output logic [4:0]        rd,
    output logic              halted
);

    // ------------------------------------------------------------------------
    // Halt latch state encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc_1;
    logic              r_pred_taken;
    logic              r_valid;
    halt_state_t       r_state;
    logic              r_halted;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // ------------------------------------------------------------------------
    // Decode fields, taken from the latched IF/ID contents only
    // ------------------------------------------------------------------------
    logic [5:0] w_opcode;
    logic [4:0] w_rs_addr;
    logic [4:0] w_rt_addr;
    logic       w_hazard;
    logic       w_halt_dec;
    logic       w_wb_hit;

    assign w_opcode  = r_instr[31:26];
    assign w_rs_addr = r_instr[25:21];
    assign w_rt_addr = r_instr[20:16];

    // rt is compared even for formats that do not read it: a spurious stall
    // costs one cycle, a missed one corrupts data.
    assign w_hazard = r_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == w_rs_addr) || (ex_rd == w_rt_addr));

    // The halt instruction itself must issue, so it is only recognised once
    // it is actually leaving decode (valid and not stalled).
    assign w_halt_dec = r_valid && !w_hazard && (w_opcode == HALT_OP);

    // Writes to r0 are dropped everywhere, including the bypass path.
    assign w_wb_hit = wb_we && (wb_rd != 5'd0);

    // ------------------------------------------------------------------------
    // IF/ID pipeline register: flush beats stall/halt, which beat capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr      <= NOP_INSTR;
            r_pc_1       <= '0;
            r_pred_taken <= 1'b0;
            r_valid      <= 1'b0;
        end else if (changeFlow) begin
            r_instr      <= NOP_INSTR;
            r_pred_taken <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!(w_hazard || r_halted)) begin
            r_instr      <= if_instr;
            r_pc_1       <= if_pc_1;
            r_pred_taken <= if_pred_taken;
            r_valid      <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Halt latch: enter on an issuing halt, leave only on redirect or reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!changeFlow && w_halt_dec) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (changeFlow) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register file write port; writeback is never blocked by the pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_hit) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read port A with same-cycle writeback bypass
    // ------------------------------------------------------------------------
    always_comb begin
        rs_data = '0;
        if (w_rs_addr != 5'd0) begin
            if (w_wb_hit && (wb_rd == w_rs_addr)) begin
                rs_data = wb_data;
            end else begin
                rs_data = r_regs[w_rs_addr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read port B with same-cycle writeback bypass
    // ------------------------------------------------------------------------
    always_comb begin
        rt_data = '0;
        if (w_rt_addr != 5'd0) begin
            if (w_wb_hit && (wb_rd == w_rt_addr)) begin
                rt_data = wb_data;
            end else begin
                rt_data = r_regs[w_rt_addr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stall_PC      = w_hazard || r_halted;
    assign id_valid      = r_valid && !w_hazard && !r_halted;
    assign id_instr      = r_instr;
    assign id_pc_1       = r_pc_1;
    assign id_pred_taken = r_pred_taken;
    assign imm_sext      = {{(DATA_W-16){r_instr[15]}}, r_instr[15:0]};
    assign rd            = r_instr[15:11];
    assign halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage: directed scenarios followed
//                by randomized traffic, compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_stage;

    localparam logic [5:0] HALT_OP = 6'b110001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instr;
    logic [31:0] if_pc_1;
    logic        if_pred_taken;
    logic        changeFlow;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_PC;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_1;
    logic        id_pred_taken;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_sext;
    logic [4:0]  rd;
    logic        halted;

    always #5 clk = ~clk;

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_instr     (if_instr),
        .if_pc_1      (if_pc_1),
        .if_pred_taken(if_pred_taken),
        .changeFlow   (changeFlow),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall_PC     (stall_PC),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc_1      (id_pc_1),
        .id_pred_taken(id_pred_taken),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .imm_sext     (imm_sext),
        .rd           (rd),
        .halted       (halted)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_pc1;
    logic        m_pred;
    logic        m_valid;
    logic        m_halted;

    function automatic logic m_hazard();
        logic [4:0] s = m_instr[25:21];
        logic [4:0] t = m_instr[20:16];
        return m_valid && ex_mem_read && (ex_rd != 0) && (ex_rd == s || ex_rd == t);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_we && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_instr  = 32'd0;
        m_pc1    = 32'd0;
        m_pred   = 1'b0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock of the model, using the inputs that were stable at the edge
    task automatic model_clock();
        logic hz;
        logic next_halted;
        hz = m_hazard();
        if (changeFlow)
            next_halted = 1'b0;
        else if (m_valid && !hz && m_instr[31:26] == HALT_OP)
            next_halted = 1'b1;
        else
            next_halted = m_halted;
        if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
        if (changeFlow) begin
            m_instr = 32'd0;
            m_valid = 1'b0;
            m_pred  = 1'b0;
        end else if (!(hz || m_halted)) begin
            m_instr = if_instr;
            m_pc1   = if_pc_1;
            m_pred  = if_pred_taken;
            m_valid = 1'b1;
        end
        m_halted = next_halted;
    endtask

    task automatic check_all();
        logic hz;
        hz = m_hazard();
        chk("stall_PC", 32'(stall_PC), 32'(hz | m_halted));
        chk("id_valid", 32'(id_valid), 32'(m_valid & ~hz & ~m_halted));
        chk("id_instr", id_instr, m_instr);
        chk("id_pc_1", id_pc_1, m_pc1);
        chk("id_pred_taken", 32'(id_pred_taken), 32'(m_pred));
        chk("rs_data", rs_data, m_read(m_instr[25:21]));
        chk("rt_data", rt_data, m_read(m_instr[20:16]));
        chk("imm_sext", imm_sext, 32'($signed(m_instr[15:0])));
        chk("rd", 32'(rd), 32'(m_instr[15:11]));
        chk("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc1, input logic pred,
                         input logic cf, input logic emr, input logic [4:0] exrd,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wdata);
        if_instr      = instr;
        if_pc_1       = pc1;
        if_pred_taken = pred;
        changeFlow    = cf;
        ex_mem_read   = emr;
        ex_rd         = exrd;
        wb_we         = we;
        wb_rd         = wrd;
        wb_data       = wdata;
    endtask

    // Let inputs settle then compare everything against the model
    task automatic settle();
        #1;
        check_all();
    endtask

    // Cross the next rising edge, update the model, park on the falling edge
    task automatic advance();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] low);
        return {op, s, t, low};
    endfunction

    initial begin
        logic [31:0] ri;
        rst = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        settle();                                   // reset state
        rst = 1'b0;

        // Streaming with no hazards
        for (int p = 1; p <= 4; p++) begin
            drive(32'h08221800, 32'(p), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
            settle();
            advance();
            chk("stream_pc", id_pc_1, 32'(p));
            chk("stream_valid", 32'(id_valid), 32'd1);
        end

        // Load-use stall: one bubble, then the same instruction re-issues
        drive(mk(6'd0, 5'd5, 5'd6, 16'h3800), 32'd10, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        settle();
        advance();
        drive(mk(6'd0, 5'd1, 5'd2, 16'h0000), 32'd11, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
        settle();
        chk("lu_stall", 32'(stall_PC), 32'd1);
        chk("lu_bubble", 32'(id_valid), 32'd0);
        advance();
        ex_mem_read = 1'b0;
        settle();
        chk("lu_reissue_valid", 32'(id_valid), 32'd1);
        chk("lu_reissue_pc", id_pc_1, 32'd10);
        advance();

        // Flush during an active hazard
        drive(mk(6'd0, 5'd5, 5'd0, 16'h0000), 32'd12, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        settle();
        advance();
        drive(mk(6'd0, 5'd1, 5'd1, 16'h0000), 32'd13, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
        settle();
        chk("flush_pre_stall", 32'(stall_PC), 32'd1);
        advance();
        changeFlow = 1'b0;
        settle();
        chk("flush_instr", id_instr, 32'd0);
        chk("flush_stall", 32'(stall_PC), 32'd0);
        // Load with ex_rd = 0 against rs = rt = 0 never stalls
        drive(mk(6'd0, 5'd0, 5'd0, 16'h0000), 32'd14, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        advance();
        ex_mem_read = 1'b1;
        settle();
        chk("rd0_no_stall", 32'(stall_PC), 32'd0);

        // Register file bypass and r0
        drive(mk(6'd0, 5'd3, 5'd0, 16'h8001), 32'd15, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        settle();
        advance();
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        settle();
        chk("bypass_same_cycle", rs_data, 32'hDEADBEEF);
        advance();
        wb_we = 1'b0;
        settle();
        chk("bypass_persist", rs_data, 32'hDEADBEEF);
        drive(mk(6'd0, 5'd0, 5'd3, 16'h0000), 32'd16, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        advance();
        settle();
        chk("r0_zero", rs_data, 32'd0);
        advance();
        wb_we = 1'b0;
        settle();
        chk("r0_zero_after", rs_data, 32'd0);
        chk("rt_r3", rt_data, 32'hDEADBEEF);

        // Halt: issues once, then freezes decode until a redirect
        drive(mk(HALT_OP, 5'd0, 5'd0, 16'h0000), 32'd20, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        advance();
        drive(32'd0, 32'd21, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        settle();
        chk("halt_issue", 32'(id_valid), 32'd1);
        advance();
        for (int k = 0; k < 10; k++) begin
            if_pc_1 = 32'(22 + k);
            settle();
            chk("halt_held", 32'(halted), 32'd1);
            chk("halt_stall", 32'(stall_PC), 32'd1);
            chk("halt_bubble", 32'(id_valid), 32'd0);
            advance();
        end
        changeFlow = 1'b1;
        settle();
        advance();
        changeFlow = 1'b0;
        settle();
        chk("halt_release", 32'(halted), 32'd0);

        // Asynchronous reset in the middle of a stall
        drive(mk(6'd0, 5'd7, 5'd3, 16'hFFFF), 32'd40, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        advance();
        ex_mem_read = 1'b1; ex_rd = 5'd7;
        settle();
        chk("ar_pre_stall", 32'(stall_PC), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_stall", 32'(stall_PC), 32'd0);
        chk("ar_valid", 32'(id_valid), 32'd0);
        chk("ar_instr", id_instr, 32'd0);
        chk("ar_rs", rs_data, 32'd0);
        chk("ar_rt", rt_data, 32'd0);
        chk("ar_imm", imm_sext, 32'd0);
        model_reset();
        advance();
        rst = 1'b0;
        ex_mem_read = 1'b0;
        settle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ri = mk(($urandom_range(0, 11) == 0) ? HALT_OP : 6'($urandom),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            drive(ri, $urandom, 1'($urandom),
                  ($urandom_range(0, 7) == 0),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  $urandom);
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage directly downstream of instruction fetch. It holds the IF/ID pipeline register: instruction, pc+1, predicted-taken bit and a valid bit. It contains the 32x32 register file with write-through bypass and detects load-use hazards, which stall fetch and insert a bubble toward EX. A decoded halt is latched so downstream logic can drain.

Parameters:
NUM_REGS, 32, number of architectural registers (r0 hardwired to zero)
DATA_W, 32, register and instruction width
HALT_OP, 6'b110001, opcode that freezes decode
NOP_INSTR, 32'h00000000, instruction value loaded on flush or reset

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
if_instr  input  32  instruction from fetch
if_pc_1  input  32  pc+1 from fetch
if_pred_taken  input  1  fetch-side branch prediction
changeFlow  input  1  EX-resolved redirect; flushes IF/ID
ex_mem_read  input  1  instruction currently in EX is a load
ex_rd  input  5  destination register of EX instruction
wb_we  input  1  register file write enable
wb_rd  input  5  write address
wb_data  input  32  write data
stall_PC  output  1  holds fetch PC (load-use hazard)
id_valid  output  1  decoded instruction valid toward EX (0 = bubble)
id_instr  output  32  latched instruction
id_pc_1  output  32  latched pc+1
id_pred_taken  output  1  latched prediction
rs_data  output  32  register file read port A (instr[25:21])
rt_data  output  32  register file read port B (instr[20:16])
imm_sext  output  32  sign-extended instr[15:0]
rd  output  5  instr[15:11]
halted  output  1  halt decoded and latched

Behaviour:
- Reset (async, rst=1):
  - IF/ID instr=NOP_INSTR, pc_1=0, pred_taken=0, valid=0, halted=0.
  - All registers cleared to 0.
  - Outputs: stall_PC=0, id_valid=0, rs_data=rt_data=0, imm_sext=0, rd=0.
  - Deassertion mid-stream: the first posedge after deassertion captures if_* normally.
- IF/ID register update priority, each posedge:
  - 1. changeFlow=1: load NOP_INSTR, valid=0, pred_taken=0, halted=0. Flush wins over stall and halt.
  - 2. hazard=1 or halted=1: hold all contents.
  - 3. Otherwise: capture if_instr, if_pc_1, if_pred_taken; valid=1.
- Hazard (combinational):
  - hazard = valid & ex_mem_read & (ex_rd!=0) & (ex_rd==instr[25:21] | ex_rd==instr[20:16]).
  - rt is compared unconditionally (conservative).
  - stall_PC = hazard | halted.
  - id_valid = valid & ~hazard & ~halted. The held instruction re-issues on the cycle after the hazard clears.
  - A load-use pair costs exactly 1 bubble.
- Halt latch:
  - Two states: RUN and HALTED.
  - RUN->HALTED when an instruction with opcode HALT_OP is decoded with valid=1 and hazard=0.
  - In HALTED, id_valid=0 from the next cycle.
  - HALTED->RUN only on changeFlow or reset.
  - The halt instruction itself issues once with id_valid=1.
- Register file:
  - 32 x 32-bit, write on posedge when wb_we=1 and wb_rd!=0. Writes to r0 are discarded.
  - Two combinational read ports. r0 always reads 0.
  - Bypass: if wb_we=1, wb_rd!=0 and wb_rd matches a read address, that port returns wb_data in the same cycle.
  - Writes occur regardless of stall, flush or halt.
- imm_sext = {{16{instr[15]}}, instr[15:0]}. rd = instr[15:11]. All decode is from latched IF/ID contents.

Test Plan:
- Reset then streaming: rst pulse, feed instr 32'h08221800 at pc_1=1..4 with no hazards -> id_valid=1 one cycle after each capture, id_pc_1 tracks 1,2,3,4, stall_PC=0.
- Load-use stall: ex_mem_read=1, ex_rd=5 while latched instr has rs=5 -> stall_PC=1 and id_valid=0 for 1 cycle. Next cycle, with ex_mem_read=0, the same instr issues with id_valid=1 and id_pc_1 unchanged.
- Flush priority: changeFlow=1 during an active hazard -> next posedge instr=0, valid=0, stall_PC=0. ex_rd=0 with a load never stalls.
- RF bypass/r0: wb_we=1, wb_rd=3, wb_data=32'hDEADBEEF with latched rs=3 -> rs_data=DEADBEEF same cycle, persists after. wb_rd=0 write of 32'hFFFFFFFF -> r0 reads 0.
- Halt: latch opcode 110001 -> one id_valid=1 cycle, then halted=1, stall_PC=1, id_valid=0 held for 10 cycles. changeFlow=1 -> halted=0 next cycle.
- Async reset mid-stall: assert rst between clock edges during a hazard -> outputs zero immediately, without waiting for a clock edge.
